axi_ram_slave: RTL and testbench

//  AXI4 slave responder with on-chip RAM; the far end of the system's DDR AXI master port.

---
 rtl/axi_ram_slave.sv | 244 ++++++++++++++++++++++++
 tb/tb_axi_ram_slave.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ram_slave.sv
// axi_ram_slave: AXI4 slave with on-chip RAM.
// It stands in for the DDR controller. It serves one INCR/FIXED burst at a time
// and returns OKAY or SLVERR. Beats are always 4 bytes wide. The word index is
// addr[MEM_ADDR_W+1:2], and higher address bits alias.
// Optional feature: define AXI_RAM_SLAVE_WRAP_EN to support WRAP bursts (len 1/3/7/15).
// Without that macro, WRAP is handled exactly like INCR.
// o_dbg_state encodes the FSM state: 0 IDLE, 1 W_DATA, 2 W_RESP, 3 R_ADDR, 4 R_DATA.
//
// Handshake semantics: a transfer on any channel happens on the rising clk edge
// where both valid and ready are 1. A source holds valid and its payload stable
// until that edge. Here, ready may depend combinationally on valid (AW/AR only),
// and valid never depends on ready.
`ifndef DDR_ADDR_W
`define DDR_ADDR_W 32
`endif

module axi_ram_slave #(
    parameter int ADDR_W     = `DDR_ADDR_W,
    parameter int DATA_W     = 32,
    parameter int MEM_ADDR_W = 16,
    parameter int ID_W       = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ID_W-1:0]     s_axi_awid,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic [7:0]          s_axi_awlen,
    input  logic [2:0]          s_axi_awsize,
    input  logic [1:0]          s_axi_awburst,
    input  logic                s_axi_awlock,
    input  logic [3:0]          s_axi_awcache,
    input  logic [2:0]          s_axi_awprot,
    input  logic [3:0]          s_axi_awqos,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [ID_W-1:0]     s_axi_bid,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ID_W-1:0]     s_axi_arid,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic [7:0]          s_axi_arlen,
    input  logic [2:0]          s_axi_arsize,
    input  logic [1:0]          s_axi_arburst,
    input  logic                s_axi_arlock,
    input  logic [3:0]          s_axi_arcache,
    input  logic [2:0]          s_axi_arprot,
    input  logic [3:0]          s_axi_arqos,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [ID_W-1:0]     s_axi_rid,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready,
    output logic [2:0]          o_dbg_state
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_W_DATA = 3'd1;
    localparam logic [2:0] ST_W_RESP = 3'd2;
    localparam logic [2:0] ST_R_ADDR = 3'd3;
    localparam logic [2:0] ST_R_DATA = 3'd4;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [DATA_W-1:0]     r_mem [0:(1<<MEM_ADDR_W)-1];

    logic [2:0]            r_state;
    logic [MEM_ADDR_W-1:0] r_idx;
    logic [7:0]            r_cnt;      // beats remaining after the current one
    logic [1:0]            r_burst;
    logic                  r_nowr;     // burst is rejected: commit nothing to RAM
    logic [ID_W-1:0]       r_bid;
    logic [ID_W-1:0]       r_rid;
    logic [1:0]            r_bresp;
    logic [1:0]            r_rresp;
    logic [DATA_W-1:0]     r_rdata;
    logic                  r_rlast;

    logic [MEM_ADDR_W-1:0] w_inc_idx;
    logic [MEM_ADDR_W-1:0] w_next_idx;
    logic                  w_last_beat;
    logic                  w_mem_we;
    logic                  w_aw_bad;
    logic                  w_ar_bad;
    logic                  w_unused;

    assign s_axi_awready = (r_state == ST_IDLE) && s_axi_awvalid;
    assign s_axi_arready = (r_state == ST_IDLE) && !s_axi_awvalid && s_axi_arvalid;
    assign s_axi_wready  = (r_state == ST_W_DATA);
    assign s_axi_bvalid  = (r_state == ST_W_RESP);
    assign s_axi_rvalid  = (r_state == ST_R_DATA);
    assign s_axi_bid     = r_bid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_rid     = r_rid;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rlast   = r_rlast;
    assign o_dbg_state   = r_state;

    assign w_last_beat = (r_cnt == 8'd0);
    assign w_mem_we    = (r_state == ST_W_DATA) && s_axi_wvalid && !r_nowr;
    assign w_inc_idx   = r_idx + 1'b1;

    // Size, cache attributes and the address bits outside the RAM window are
    // deliberately ignored.
    assign w_unused = ^{s_axi_awsize, s_axi_awlock, s_axi_awcache, s_axi_awprot,
                        s_axi_awqos, s_axi_awaddr, s_axi_arsize, s_axi_arlock,
                        s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_araddr};

`ifdef AXI_RAM_SLAVE_WRAP_EN
    logic [3:0]            r_mask;     // len of a legal WRAP burst = word-offset mask
    logic [MEM_ADDR_W-1:0] w_mask;

    assign w_mask   = {{(MEM_ADDR_W-4){1'b0}}, r_mask};
    assign w_aw_bad = (s_axi_awburst == 2'b10) && !(s_axi_awlen inside {8'd1, 8'd3, 8'd7, 8'd15});
    assign w_ar_bad = (s_axi_arburst == 2'b10) && !(s_axi_arlen inside {8'd1, 8'd3, 8'd7, 8'd15});

    // Capture the wrap mask with the address so the wrap boundary is known per burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask <= 4'd0;
        end else if (s_axi_awready) begin
            r_mask <= s_axi_awlen[3:0];
        end else if (s_axi_arready) begin
            r_mask <= s_axi_arlen[3:0];
        end
    end
`else
    assign w_aw_bad = 1'b0;
    assign w_ar_bad = 1'b0;
`endif

    // Next word index: FIXED holds it, WRAP stays inside its aligned window, and
    // everything else increments modulo the RAM depth.
    always_comb begin
        w_next_idx = w_inc_idx;
        if (r_burst == BURST_FIXED) begin
            w_next_idx = r_idx;
        end
`ifdef AXI_RAM_SLAVE_WRAP_EN
        else if (r_burst == 2'b10) begin
            w_next_idx = (r_idx & ~w_mask) | (w_inc_idx & w_mask);
        end
`endif
    end

    // RAM byte-lane writes. There is no reset, so contents survive rst.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (s_axi_wstrb[b]) begin
                    r_mem[r_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                end
            end
        end
    end

    // Transaction FSM: address capture, beat counting, wlast checking and the read pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_cnt   <= 8'd0;
            r_burst <= 2'b00;
            r_nowr  <= 1'b0;
            r_bid   <= '0;
            r_rid   <= '0;
            r_bresp <= RESP_OKAY;
            r_rresp <= RESP_OKAY;
            r_rdata <= '0;
            r_rlast <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (s_axi_awvalid) begin
                        r_bid   <= s_axi_awid;
                        r_idx   <= s_axi_awaddr[MEM_ADDR_W+1:2];
                        r_cnt   <= s_axi_awlen;
                        r_burst <= s_axi_awburst;
                        r_nowr  <= w_aw_bad;
                        r_bresp <= w_aw_bad ? RESP_SLVERR : RESP_OKAY;
                        r_state <= ST_W_DATA;
                    end else if (s_axi_arvalid) begin
                        r_rid   <= s_axi_arid;
                        r_idx   <= s_axi_araddr[MEM_ADDR_W+1:2];
                        r_cnt   <= s_axi_arlen;
                        r_burst <= s_axi_arburst;
                        r_rresp <= w_ar_bad ? RESP_SLVERR : RESP_OKAY;
                        r_state <= ST_R_ADDR;
                    end
                end
                ST_W_DATA: begin
                    if (s_axi_wvalid) begin
                        // wlast must coincide with the final beat. An early wlast
                        // closes the burst, and a missing one does not extend it.
                        if (s_axi_wlast != w_last_beat) begin
                            r_bresp <= RESP_SLVERR;
                        end
                        if (s_axi_wlast || w_last_beat) begin
                            r_state <= ST_W_RESP;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                            r_idx <= w_next_idx;
                        end
                    end
                end
                ST_W_RESP: begin
                    if (s_axi_bready) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_R_ADDR: begin
                    r_rdata <= r_mem[r_idx];
                    r_rlast <= w_last_beat;
                    r_state <= ST_R_DATA;
                end
                ST_R_DATA: begin
                    if (s_axi_rready) begin
                        if (w_last_beat) begin
                            r_rlast <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt   <= r_cnt - 1'b1;
                            r_idx   <= w_next_idx;
                            r_state <= ST_R_ADDR;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Testbench for axi_ram_slave: directed bursts checked against a word-level memory model.
module tb_axi_ram_slave;

    localparam int TMO = 60;
`ifdef AXI_RAM_SLAVE_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif
    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        awid = 1'b0, awvalid = 1'b0, awready;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [1:0]  awburst = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0, wvalid = 1'b0, wready;
    logic        bid, bvalid, bready = 1'b0;
    logic [1:0]  bresp;
    logic        arid = 1'b0, arvalid = 1'b0, arready;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [1:0]  arburst = '0;
    logic        rid, rlast, rvalid, rready = 1'b0;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [2:0]  dbg_state;

    axi_ram_slave #(.ADDR_W(32), .DATA_W(32), .MEM_ADDR_W(16), .ID_W(1)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(3'd2),
        .s_axi_awburst(awburst), .s_axi_awlock(1'b0), .s_axi_awcache(4'd0), .s_axi_awprot(3'd0),
        .s_axi_awqos(4'd0), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
        .s_axi_wready(wready), .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
        .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(3'd2),
        .s_axi_arburst(arburst), .s_axi_arlock(1'b0), .s_axi_arcache(4'd0), .s_axi_arprot(3'd0),
        .s_axi_arqos(4'd0), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready), .o_dbg_state(dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- model and scoreboard state ----------------
    logic [31:0] model_mem [int unsigned];
    logic [2:0]  exp_b_q [$];   // {id, resp}
    logic [36:0] exp_r_q [$];   // {dont_care_data, id, resp, last, data}
    logic [31:0] wbuf [256];
    logic [3:0]  sbuf [256];
    logic [31:0] rbuf [256];
    logic        rlbuf [256];
    int          rcount = 0;
    logic [1:0]  last_bresp = 2'b11;
    int          vectors = 0;
    int          miscompares = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void fail_note(input string name, input string what);
        vectors++;
        miscompares++;
        $display("FAIL %s: %s", name, what);
    endfunction

    function automatic bit wrap_illegal(input logic [1:0] burst, input int len);
        return WRAP_EN && (burst == WRAP) && !(len == 1 || len == 3 || len == 7 || len == 15);
    endfunction

    // Word that beat number 'beat' of a burst lands on.
    function automatic int unsigned beat_word(input logic [31:0] addr, input int len,
                                              input logic [1:0] burst, input int beat);
        int unsigned w, span, base;
        w = 32'(addr[17:2]);
        if (burst == FIXED) return w;
        if (burst == WRAP && WRAP_EN) begin
            span = len + 1;
            base = w - (w % span);
            return base + ((w - base + beat) % span);
        end
        return (w + beat) % 65536;
    endfunction

    function automatic void model_write(input int unsigned w, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] cur;
        cur = model_mem.exists(w) ? model_mem[w] : 32'h0;
        for (int i = 0; i < 4; i++) if (s[i]) cur[8*i +: 8] = d[8*i +: 8];
        model_mem[w] = cur;
    endfunction

    // ---------------- compare process ----------------
    logic        aw_open = 1'b0, ar_open = 1'b0, prev_stall = 1'b0, prev_rlast = 1'b0;
    logic [31:0] prev_rdata = '0;

    always @(negedge clk) begin
        logic [2:0]  eb;
        logic [36:0] er;
        if (rst) begin
            aw_open = 1'b0;
            ar_open = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if ((aw_open || ar_open) && (awvalid || arvalid))
                check("one_txn_at_a_time", {awready, arready}, 2'b00);
            if (prev_stall) begin
                check("r_stall_valid", rvalid, 1'b1);
                check("r_stall_data", rdata, prev_rdata);
                check("r_stall_last", rlast, prev_rlast);
            end
            prev_stall = rvalid && !rready;
            prev_rdata = rdata;
            prev_rlast = rlast;
            if (bvalid && bready) begin
                if (exp_b_q.size() == 0) fail_note("b_unexpected", "B response with nothing outstanding");
                else begin
                    eb = exp_b_q.pop_front();
                    check("b_resp", bresp, eb[1:0]);
                    check("b_id", bid, eb[2]);
                end
                last_bresp = bresp;
                aw_open = 1'b0;
            end
            if (rvalid && rready) begin
                if (exp_r_q.size() == 0) fail_note("r_unexpected", "R beat with nothing outstanding");
                else begin
                    er = exp_r_q.pop_front();
                    if (!er[36]) check("r_data", rdata, er[31:0]);
                    check("r_last", rlast, er[32]);
                    check("r_resp", rresp, er[34:33]);
                    check("r_id", rid, er[35]);
                end
                rbuf[rcount] = rdata;
                rlbuf[rcount] = rlast;
                rcount++;
                if (rlast) ar_open = 1'b0;
            end
            if (awvalid && awready) aw_open = 1'b1;
            if (arvalid && arready) ar_open = 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    // Beats come from wbuf/sbuf. wlast is raised on beat 'last_at'; a negative value means never.
    task automatic axi_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                             input logic id, input int last_at);
        int  nbeats, n;
        bit  bad;
        bad    = wrap_illegal(burst, len);
        nbeats = (last_at >= 0 && last_at < len) ? last_at + 1 : len + 1;
        awid = id; awaddr = addr; awlen = len[7:0]; awburst = burst; awvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!awready && n < TMO) begin @(negedge clk); n++; end
        if (!awready) fail_note("aw_handshake", "timed out waiting for awready");
        exp_b_q.push_back({id, (bad || last_at != len) ? 2'b10 : 2'b00});
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            wdata = wbuf[b]; wstrb = sbuf[b]; wlast = (b == last_at); wvalid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!wready && n < TMO) begin @(negedge clk); n++; end
            if (!wready) fail_note("w_handshake", "timed out waiting for wready");
            if (!bad) model_write(beat_word(addr, len, burst, b), wbuf[b], sbuf[b]);
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        bready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bvalid && n < TMO) begin @(negedge clk); n++; end
        if (!bvalid) fail_note("b_handshake", "timed out waiting for bvalid");
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                            input logic id, input bit stall, input bit chk_lat);
        int          n, got, lat, first_lat;
        bit          bad;
        int unsigned w;
        bad = wrap_illegal(burst, len);
        rcount = 0;
        arid = id; araddr = addr; arlen = len[7:0]; arburst = burst; arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!arready && n < TMO) begin @(negedge clk); n++; end
        if (!arready) fail_note("ar_handshake", "timed out waiting for arready");
        for (int b = 0; b <= len; b++) begin
            w = beat_word(addr, len, burst, b);
            exp_r_q.push_back({bad || !model_mem.exists(w), id, bad ? 2'b10 : 2'b00, b == len,
                               model_mem.exists(w) ? model_mem[w] : 32'h0});
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        rready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        got = 0; lat = 0; first_lat = -1; n = 0;
        while (got < len + 1 && n < TMO * (len + 1)) begin
            @(negedge clk);
            lat++;
            if (rvalid && first_lat < 0) first_lat = lat;
            if (rvalid && rready) got++;
            @(posedge clk); #1;
            rready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            n++;
        end
        rready = 1'b0;
        if (got < len + 1) fail_note("r_beats", "timed out before all read beats arrived");
        if (chk_lat) check("ar_to_rvalid_latency", first_lat, 2);
    endtask

    task automatic fill(input logic [31:0] start, input logic [31:0] step);
        for (int i = 0; i < 256; i++) begin
            wbuf[i] = start + step * i;
            sbuf[i] = 4'hF;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_awready", awready, 1'b0);
        check("rst_arready", arready, 1'b0);
        check("rst_wready", wready, 1'b0);
        check("rst_bvalid_bresp_bid", {bvalid, bresp, bid}, 4'd0);
        check("rst_rvalid_rresp_rlast", {rvalid, rresp, rlast}, 4'd0);
        check("rst_rdata_rid", {rdata, rid}, 33'd0);
        check("rst_state_idle", dbg_state, 3'd0);
        @(posedge clk); #1;

        // 1: single beat write and read back
        fill(32'hDEADBEEF, 0);
        axi_write(32'h10, 0, INCR, 1'b1, 0);
        check("t1_bresp", last_bresp, 2'b00);
        axi_read(32'h10, 0, INCR, 1'b0, 1'b0, 1'b1);
        check("t1_rdata", rbuf[0], 32'hDEADBEEF);
        check("t1_rlast", rlbuf[0], 1'b1);

        // 2: 4-beat INCR, read with random rready stalls
        fill(32'd1, 32'd1);
        axi_write(32'h100, 3, INCR, 1'b0, 3);
        axi_read(32'h100, 3, INCR, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("t2_rdata", rbuf[i], 32'(i + 1));
            check("t2_rlast", rlbuf[i], (i == 3));
        end

        // 3: partial strobes
        fill(32'hFFFFFFFF, 0);
        axi_write(32'h20, 0, INCR, 1'b0, 0);
        fill(32'h0, 0);
        sbuf[0] = 4'b0101;
        axi_write(32'h20, 0, INCR, 1'b0, 0);
        axi_read(32'h20, 0, INCR, 1'b0, 1'b0, 1'b0);
        check("t3_rdata", rbuf[0], 32'hFF00FF00);

        // 4: AW and AR in the same cycle, same address
        fill(32'hCAFEF00D, 0);
        fork
            axi_write(32'h60, 0, INCR, 1'b0, 0);
            axi_read(32'h60, 0, INCR, 1'b1, 1'b0, 1'b0);
        join
        check("t4_rdata", rbuf[0], 32'hCAFEF00D);

        // 5: early and missing wlast
        fill(32'hA0, 1);
        axi_write(32'h200, 3, INCR, 1'b0, 3);
        fill(32'hE0, 1);
        axi_write(32'h200, 3, INCR, 1'b1, 1);
        check("t5_early_wlast_bresp", last_bresp, 2'b10);
        axi_read(32'h200, 3, INCR, 1'b0, 1'b0, 1'b0);
        check("t5_beat0", rbuf[0], 32'hE0);
        check("t5_beat1", rbuf[1], 32'hE1);
        check("t5_beat2", rbuf[2], 32'hA2);
        check("t5_beat3", rbuf[3], 32'hA3);
        fill(32'h55, 0);
        axi_write(32'h210, 0, INCR, 1'b0, 0);
        check("t5_legal_bresp", last_bresp, 2'b00);
        fill(32'h70, 1);
        axi_write(32'h220, 1, INCR, 1'b0, -1);
        check("t5_missing_wlast_bresp", last_bresp, 2'b10);
        axi_read(32'h220, 1, INCR, 1'b0, 1'b0, 1'b0);
        check("t5_missing_wlast_data", {rbuf[0], rbuf[1]}, {32'h70, 32'h71});

        // 6: WRAP len 3 at 0x18
        fill(32'hB0, 1);
        axi_write(32'h18, 3, WRAP, 1'b0, 3);
`ifdef AXI_RAM_SLAVE_WRAP_EN
        axi_read(32'h10, 3, INCR, 1'b0, 1'b0, 1'b0);
        check("t6_wrap_words", {rbuf[0], rbuf[1], rbuf[2], rbuf[3]}, {32'hB2, 32'hB3, 32'hB0, 32'hB1});
`else
        axi_read(32'h18, 3, INCR, 1'b0, 1'b0, 1'b0);
        check("t6_incr_words", {rbuf[0], rbuf[1], rbuf[2], rbuf[3]}, {32'hB0, 32'hB1, 32'hB2, 32'hB3});
`endif

        // FIXED burst: every beat hits one word; the last beat wins
        fill(32'hF0, 1);
        axi_write(32'h400, 2, FIXED, 1'b1, 2);
        axi_read(32'h400, 2, FIXED, 1'b1, 1'b1, 1'b0);
        check("fixed_data", {rbuf[0], rbuf[1], rbuf[2]}, {32'hF2, 32'hF2, 32'hF2});

        // Address aliasing above the RAM window
        fill(32'h600D0001, 0);
        axi_write(32'h0004_0050, 0, INCR, 1'b0, 0);
        axi_read(32'h50, 0, INCR, 1'b0, 1'b0, 1'b0);
        check("alias_data", rbuf[0], 32'h600D0001);

        // WRAP with an unsupported length
        fill(32'hC0, 1);
        axi_write(32'h500, 2, INCR, 1'b0, 2);
        fill(32'hD0, 1);
        axi_write(32'h500, 2, WRAP, 1'b0, 2);
        check("badwrap_bresp", last_bresp, WRAP_EN ? 2'b10 : 2'b00);
        axi_read(32'h500, 2, INCR, 1'b0, 1'b0, 1'b0);
        check("badwrap_ram", rbuf[1], WRAP_EN ? 32'hC1 : 32'hD1);
        axi_read(32'h500, 2, WRAP, 1'b1, 1'b0, 1'b0);

        // 256-beat burst
        fill(32'h10000000, 3);
        axi_write(32'h1000, 255, INCR, 1'b1, 255);
        axi_read(32'h1000, 255, INCR, 1'b0, 1'b0, 1'b0);
        check("len255_beats", rcount, 256);
        check("len255_last", {rbuf[255], rlbuf[255], rlbuf[254]}, {32'h100002FD, 1'b1, 1'b0});

        // Reset in the middle of a write burst: committed beats stay in RAM
        fill(32'h11111111, 32'h11111111);
        axi_write(32'h300, 1, INCR, 1'b0, 1);
        awaddr = 32'h300; awlen = 8'd3; awburst = INCR; awvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!awready && n < TMO) begin @(negedge clk); n++; end
        if (!awready) fail_note("midrst_aw", "timed out waiting for awready");
        @(posedge clk); #1;
        awvalid = 1'b0;
        wdata = 32'h33333333; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!wready && n < TMO) begin @(negedge clk); n++; end
        if (!wready) fail_note("midrst_w", "timed out waiting for wready");
        model_write(32'h300 >> 2, 32'h33333333, 4'hF);
        @(posedge clk); #1;
        wvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_outputs", {wready, bvalid, rvalid, dbg_state}, 6'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        axi_read(32'h300, 1, INCR, 1'b0, 1'b0, 1'b0);
        check("midrst_data", {rbuf[0], rbuf[1]}, {32'h33333333, 32'h22222222});

        repeat (2) @(posedge clk);
        check("b_queue_drained", exp_b_q.size(), 0);
        check("r_queue_drained", exp_r_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
